pic_core_n: RTL and testbench

Synchronous, parametrised successor to the 8259-style PIC: NUM_IRQ request lines, per-line mask, IRR/ISR/IMR registers, fully-nested or automatic-rotating priority, edge or level triggering, normal or automatic EOI, and a two-pulse INTA acknowledge that returns an 8-bit vector. Sits between I/O request sources and the CPU bus model; single clock, no cascade.

---
 rtl/pic_pkg.sv | 28 ++
 rtl/pic_prio_resolver.sv | 36 +++
 rtl/pic_core_n.sv | 210 +++++++++++++++++++++
 tb/tb_pic_core_n.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
//------------------------------------------------------------------------------
// pic_pkg : shared types and encodings for the pic_core_n interrupt controller
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pic_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WAIT2 = 1'b1
    } state_t;

    // Command field din[7:6] for a0=0 writes
    localparam logic [1:0] CMD_MODE = 2'b00;
    localparam logic [1:0] CMD_RSVD = 2'b01;
    localparam logic [1:0] CMD_EOI  = 2'b10;
    localparam logic [1:0] CMD_BASE = 2'b11;

    localparam int MODE_LTIM    = 0;
    localparam int MODE_AEOI    = 1;
    localparam int MODE_ROT     = 2;
    localparam int MODE_RIS     = 3;
    localparam int EOI_SPECIFIC = 5;

endpackage

`default_nettype wire

// File: rtl/pic_prio_resolver.sv
//------------------------------------------------------------------------------
// pic_prio_resolver : find-first over a request vector, starting just above low_ptr
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pic_prio_resolver #(
    parameter int NUM_IRQ = 8,
    parameter int L       = $clog2(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] req,
    input  logic [L-1:0]       low_ptr,
    output logic               valid,
    output logic [L-1:0]       idx
);

    logic [L-1:0] ch;

    // Scan from lowest to highest priority so the last hit is the winner;
    // the L-bit add wraps modulo NUM_IRQ because NUM_IRQ is a power of two.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        ch    = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            ch = low_ptr + L'(k + 1);
            if (req[ch]) begin
                valid = 1'b1;
                idx   = ch;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/pic_core_n.sv
//------------------------------------------------------------------------------
// pic_core_n : parametrised 8259-style interrupt controller, single clock, no cascade
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pic_core_n
    import pic_pkg::*;
#(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cs,
    input  logic               wr,
    input  logic               rd,
    input  logic               a0,
    input  logic [7:0]         din,
    output logic [7:0]         dout,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               inta,
    output logic               int_o,
    output logic               vec_valid
);

    localparam int L = $clog2(NUM_IRQ);

    state_t               state;
    logic [NUM_IRQ-1:0]   irr;
    logic [NUM_IRQ-1:0]   isr;
    logic [NUM_IRQ-1:0]   imr;
    logic [NUM_IRQ-1:0]   irq_q;
    logic [7:0]           vbase;
    logic                 base_arm;
    logic                 ltim;
    logic                 aeoi;
    logic                 rot_en;
    logic                 ris;
    logic [L-1:0]         low_ptr;
    logic [L-1:0]         win;
    logic                 spurious;

    logic                 wr_cyc;
    logic                 rd_cyc;
    logic                 eoi_cmd;
    logic                 eoi_do;
    logic [L-1:0]         eoi_ch;
    logic [NUM_IRQ-1:0]   isr_eoi;
    logic [L-1:0]         low_ptr_eoi;
    logic                 isr_top_valid;
    logic [L-1:0]         isr_top;
    logic                 req_valid;
    logic [L-1:0]         req_idx;
    logic [L-1:0]         req_rank;
    logic [L-1:0]         c_rank;
    logic                 isr_block;
    logic                 pending;
    logic                 ack1;
    logic                 ack2;
    logic                 aeoi_clr;
    logic [L-1:0]         ack_ch;
    logic [NUM_IRQ-1:0]   ack_clr;
    logic [NUM_IRQ-1:0]   hold;
    logic [NUM_IRQ-1:0]   isr_n;
    logic [NUM_IRQ-1:0]   irr_n;
    logic [L-1:0]         low_ptr_n;
    logic [7:0]           vector;

    assign wr_cyc  = cs & wr;
    assign rd_cyc  = cs & rd;
    assign eoi_cmd = wr_cyc & ~a0 & (din[7:6] == CMD_EOI);
    assign ack1    = (state == IDLE) & inta;
    assign ack2    = (state == WAIT2) & inta;
    assign vector  = (vbase & ~8'(NUM_IRQ - 1)) | 8'(win);

    pic_prio_resolver #(.NUM_IRQ(NUM_IRQ), .L(L)) u_prio_isr (
        .req     (isr),
        .low_ptr (low_ptr),
        .valid   (isr_top_valid),
        .idx     (isr_top)
    );

    pic_prio_resolver #(.NUM_IRQ(NUM_IRQ), .L(L)) u_prio_req (
        .req     (irr & ~imr),
        .low_ptr (low_ptr_eoi),
        .valid   (req_valid),
        .idx     (req_idx)
    );

    // EOI lands first so that a same-cycle acknowledge arbitrates against the
    // post-EOI in-service set and rotated pointer.
    always_comb begin
        eoi_ch      = din[EOI_SPECIFIC] ? din[L-1:0] : isr_top;
        eoi_do      = eoi_cmd & (din[EOI_SPECIFIC] | isr_top_valid);
        isr_eoi     = eoi_do ? (isr & ~(NUM_IRQ'(1) << eoi_ch)) : isr;
        low_ptr_eoi = (eoi_do & rot_en) ? eoi_ch : low_ptr;
    end

    // A request is pending only if no in-service channel ranks at or above it.
    always_comb begin
        req_rank  = req_idx - low_ptr_eoi - L'(1);
        c_rank    = '0;
        isr_block = 1'b0;
        for (int c = 0; c < NUM_IRQ; c++) begin
            c_rank = L'(c) - low_ptr_eoi - L'(1);
            if (isr_eoi[c] && (c_rank <= req_rank)) begin
                isr_block = 1'b1;
            end
        end
        pending = req_valid & ~isr_block;
    end

    always_comb begin
        ack_ch    = pending ? req_idx : low_ptr_eoi;
        ack_clr   = (ack1 & pending) ? (NUM_IRQ'(1) << req_idx) : '0;
        hold      = ((state == WAIT2) & ~spurious) ? (NUM_IRQ'(1) << win) : '0;
        aeoi_clr  = ack2 & aeoi & ~spurious;
        isr_n     = isr_eoi | ack_clr;
        if (aeoi_clr) begin
            isr_n = isr_n & ~(NUM_IRQ'(1) << win);
        end
        low_ptr_n = (aeoi_clr & rot_en) ? win : low_ptr_eoi;
        // Edge mode: a new edge beats a same-cycle acknowledge clear.
        if (ltim) begin
            irr_n = irq & ~ack_clr & ~hold;
        end else begin
            irr_n = (irr & ~ack_clr) | (irq & ~irq_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            irr       <= '0;
            isr       <= '0;
            imr       <= '1;
            irq_q     <= '0;
            vbase     <= 8'h00;
            base_arm  <= 1'b0;
            ltim      <= 1'b0;
            aeoi      <= 1'b0;
            rot_en    <= 1'b0;
            ris       <= 1'b0;
            low_ptr   <= L'(NUM_IRQ - 1);
            win       <= '0;
            spurious  <= 1'b0;
            dout      <= 8'h00;
            int_o     <= 1'b0;
            vec_valid <= 1'b0;
        end else begin
            irq_q     <= irq;
            irr       <= irr_n;
            isr       <= isr_n;
            low_ptr   <= low_ptr_n;
            vec_valid <= 1'b0;

            if (wr_cyc) begin
                if (a0) begin
                    if (base_arm) begin
                        vbase    <= din;
                        base_arm <= 1'b0;
                    end else begin
                        imr <= din[NUM_IRQ-1:0];
                    end
                end else begin
                    case (din[7:6])
                        CMD_MODE: begin
                            ltim   <= din[MODE_LTIM];
                            aeoi   <= din[MODE_AEOI];
                            rot_en <= din[MODE_ROT];
                            ris    <= din[MODE_RIS];
                        end
                        CMD_BASE: base_arm <= 1'b1;
                        CMD_RSVD: ;
                        default:  ;
                    endcase
                end
            end

            if (rd_cyc) begin
                dout <= a0 ? 8'(imr) : (ris ? 8'(isr) : 8'(irr));
            end

            case (state)
                IDLE: begin
                    if (inta) begin
                        int_o    <= 1'b0;
                        win      <= ack_ch;
                        spurious <= ~pending;
                        state    <= WAIT2;
                    end else begin
                        int_o <= pending;
                    end
                end
                WAIT2: begin
                    int_o <= 1'b0;
                    if (inta) begin
                        dout      <= vector;
                        vec_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pic_core_n.sv
//------------------------------------------------------------------------------
// tb_pic_core_n : directed self-checking bench for pic_core_n (8- and 4-line builds)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pic_core_n;

    logic       clk = 1'b0;
    logic       rst, cs, wr, rd, a0, inta;
    logic [7:0] din, irq;
    logic [7:0] dout, dout4;
    logic       int_o, vec_valid, int_o4, vec_valid4;
    int         vectors = 0;
    int         errors  = 0;

    always #5 clk = ~clk;

    pic_core_n #(.NUM_IRQ(8)) dut8 (
        .clk(clk), .rst(rst), .cs(cs), .wr(wr), .rd(rd), .a0(a0), .din(din),
        .dout(dout), .irq(irq), .inta(inta), .int_o(int_o), .vec_valid(vec_valid)
    );

    pic_core_n #(.NUM_IRQ(4)) dut4 (
        .clk(clk), .rst(rst), .cs(cs), .wr(wr), .rd(rd), .a0(a0), .din(din),
        .dout(dout4), .irq(irq[3:0]), .inta(inta), .int_o(int_o4), .vec_valid(vec_valid4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; cs = 1'b0; wr = 1'b0; rd = 1'b0; a0 = 1'b0; inta = 1'b0;
        din = 8'h00; irq = 8'h00;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic do_write(input logic a, input logic [7:0] d);
        cs = 1'b1; wr = 1'b1; a0 = a; din = d;
        tick();
        cs = 1'b0; wr = 1'b0; din = 8'h00;
    endtask

    task automatic do_read(input logic a, output logic [7:0] v8, output logic [7:0] v4);
        cs = 1'b1; rd = 1'b1; a0 = a;
        tick();
        cs = 1'b0; rd = 1'b0;
        v8 = dout;
        v4 = dout4;
    endtask

    task automatic set_base(input logic [7:0] b);
        do_write(1'b0, 8'hC0);
        do_write(1'b1, b);
    endtask

    task automatic do_ack(output logic mi8, output logic [7:0] v8, output logic vv8,
                          output logic [7:0] v4, output logic vv4);
        inta = 1'b1;
        tick();
        inta = 1'b0;
        mi8 = int_o;
        tick();
        inta = 1'b1;
        tick();
        inta = 1'b0;
        v8 = dout; vv8 = vec_valid; v4 = dout4; vv4 = vec_valid4;
    endtask

    task automatic test_reset();
        logic [7:0] r8, r4;
        apply_reset();
        vectors++; if (dout !== 8'h00) begin errors++; $display("FAIL rst_dout: got %h want 00", dout); end
        vectors++; if (int_o !== 1'b0) begin errors++; $display("FAIL rst_int: got %b want 0", int_o); end
        vectors++; if (vec_valid !== 1'b0) begin errors++; $display("FAIL rst_vv: got %b want 0", vec_valid); end
        do_read(1'b1, r8, r4);
        vectors++; if (r8 !== 8'hFF) begin errors++; $display("FAIL rst_imr8: got %h want ff", r8); end
        vectors++; if (r4 !== 8'h0F) begin errors++; $display("FAIL rst_imr4: got %h want 0f", r4); end
        do_read(1'b0, r8, r4);
        vectors++; if (r8 !== 8'h00) begin errors++; $display("FAIL rst_irr: got %h want 00", r8); end
    endtask

    task automatic test_nested();
        logic [7:0] r8, r4, v8, v4;
        logic mi, vv8, vv4;
        apply_reset();
        set_base(8'h70);
        do_write(1'b1, 8'hC2);
        do_write(1'b0, 8'h00);
        irq = 8'h96;
        tick();
        vectors++; if (int_o !== 1'b0) begin errors++; $display("FAIL nest_lat0: got %b want 0", int_o); end
        tick();
        vectors++; if (int_o !== 1'b1) begin errors++; $display("FAIL nest_lat1: got %b want 1", int_o); end
        do_read(1'b0, r8, r4);
        vectors++; if (r8 !== 8'h96) begin errors++; $display("FAIL nest_irr: got %h want 96", r8); end
        do_ack(mi, v8, vv8, v4, vv4);
        vectors++; if (mi !== 1'b0) begin errors++; $display("FAIL nest_int_drop: got %b want 0", mi); end
        vectors++; if (v8 !== 8'h72 || vv8 !== 1'b1) begin errors++; $display("FAIL nest_vec1: got %h/%b want 72/1", v8, vv8); end
        tick();
        vectors++; if (vec_valid !== 1'b0) begin errors++; $display("FAIL nest_vv_once: got %b want 0", vec_valid); end
        do_write(1'b0, 8'h08);
        do_read(1'b0, r8, r4);
        vectors++; if (r8 !== 8'h04) begin errors++; $display("FAIL nest_isr: got %h want 04", r8); end
        do_read(1'b1, r8, r4);
        vectors++; if (r8 !== 8'hC2) begin errors++; $display("FAIL nest_imr: got %h want c2", r8); end
        vectors++; if (int_o !== 1'b0) begin errors++; $display("FAIL nest_blocked: got %b want 0", int_o); end
        do_write(1'b0, 8'h80);
        do_read(1'b0, r8, r4);
        vectors++; if (r8 !== 8'h00) begin errors++; $display("FAIL nest_eoi_isr: got %h want 00", r8); end
        vectors++; if (int_o !== 1'b1) begin errors++; $display("FAIL nest_eoi_int: got %b want 1", int_o); end
        do_ack(mi, v8, vv8, v4, vv4);
        vectors++; if (v8 !== 8'h74 || vv8 !== 1'b1) begin errors++; $display("FAIL nest_vec2: got %h/%b want 74/1", v8, vv8); end
        do_read(1'b0, r8, r4);
        vectors++; if (r8 !== 8'h10) begin errors++; $display("FAIL nest_isr2: got %h want 10", r8); end
    endtask

    task automatic test_rotate();
        logic [7:0] r8, r4, v8, v4;
        logic mi, vv8, vv4;
        apply_reset();
        set_base(8'h70);
        do_write(1'b1, 8'h00);
        do_write(1'b0, 8'h04);
        irq = 8'h12;
        tick(); tick();
        do_ack(mi, v8, vv8, v4, vv4);
        vectors++; if (v8 !== 8'h71) begin errors++; $display("FAIL rot_vec1: got %h want 71", v8); end
        do_write(1'b0, 8'h80);
        irq = 8'h17;
        tick(); tick();
        do_ack(mi, v8, vv8, v4, vv4);
        vectors++; if (v8 !== 8'h72) begin errors++; $display("FAIL rot_vec2: got %h want 72", v8); end
        do_write(1'b0, 8'h0C);
        do_read(1'b0, r8, r4);
        vectors++; if (r8 !== 8'h04) begin errors++; $display("FAIL rot_isr: got %h want 04", r8); end
        do_write(1'b0, 8'h80);
        tick();
        do_ack(mi, v8, vv8, v4, vv4);
        vectors++; if (v8 !== 8'h74) begin errors++; $display("FAIL rot_vec3: got %h want 74", v8); end
    endtask

    task automatic test_aeoi();
        logic [7:0] r8, r4, v8, v4;
        logic mi, vv8, vv4;
        apply_reset();
        set_base(8'h70);
        do_write(1'b1, 8'h00);
        do_write(1'b0, 8'h0A);
        irq = 8'h28;
        tick(); tick();
        do_ack(mi, v8, vv8, v4, vv4);
        vectors++; if (v8 !== 8'h73 || vv8 !== 1'b1) begin errors++; $display("FAIL aeoi_vec1: got %h/%b want 73/1", v8, vv8); end
        tick();
        vectors++; if (int_o !== 1'b1) begin errors++; $display("FAIL aeoi_reassert: got %b want 1", int_o); end
        do_read(1'b0, r8, r4);
        vectors++; if (r8 !== 8'h00) begin errors++; $display("FAIL aeoi_isr: got %h want 00", r8); end
        do_ack(mi, v8, vv8, v4, vv4);
        vectors++; if (v8 !== 8'h75) begin errors++; $display("FAIL aeoi_vec2: got %h want 75", v8); end
    endtask

    task automatic test_spurious();
        logic [7:0] r8, r4, v8, v4;
        logic mi, vv8, vv4;
        apply_reset();
        set_base(8'h70);
        do_write(1'b1, 8'h00);
        do_write(1'b0, 8'h01);
        irq = 8'h01;
        tick(); tick();
        vectors++; if (int_o !== 1'b1) begin errors++; $display("FAIL spur_level_int: got %b want 1", int_o); end
        irq = 8'h00;
        tick(); tick();
        vectors++; if (int_o !== 1'b0) begin errors++; $display("FAIL spur_withdraw: got %b want 0", int_o); end
        do_ack(mi, v8, vv8, v4, vv4);
        vectors++; if (v8 !== 8'h77 || vv8 !== 1'b1) begin errors++; $display("FAIL spur_vec: got %h/%b want 77/1", v8, vv8); end
        do_write(1'b0, 8'h09);
        do_read(1'b0, r8, r4);
        vectors++; if (r8 !== 8'h00) begin errors++; $display("FAIL spur_isr: got %h want 00", r8); end
    endtask

    task automatic test_four_rst();
        logic [7:0] r8, r4, v8, v4;
        logic mi, vv8, vv4;
        apply_reset();
        set_base(8'h40);
        do_write(1'b1, 8'h00);
        do_write(1'b0, 8'h00);
        irq = 8'h04;
        tick(); tick();
        vectors++; if (int_o4 !== 1'b1) begin errors++; $display("FAIL n4_int: got %b want 1", int_o4); end
        do_ack(mi, v8, vv8, v4, vv4);
        vectors++; if (v4 !== 8'h42 || vv4 !== 1'b1) begin errors++; $display("FAIL n4_vec: got %h/%b want 42/1", v4, vv4); end
        do_write(1'b0, 8'h80);
        irq = 8'h00;
        tick();
        irq = 8'h04;
        tick(); tick();
        vectors++; if (int_o4 !== 1'b1) begin errors++; $display("FAIL n4_int2: got %b want 1", int_o4); end
        inta = 1'b1;
        tick();
        inta = 1'b0;
        vectors++; if (int_o4 !== 1'b0) begin errors++; $display("FAIL n4_wait2_int: got %b want 0", int_o4); end
        tick();
        irq = 8'h00;
        rst = 1'b1;
        #2;
        vectors++; if (int_o4 !== 1'b0 || vec_valid4 !== 1'b0 || dout4 !== 8'h00) begin
            errors++; $display("FAIL n4_rst_now: got int=%b vv=%b dout=%h want 0/0/00", int_o4, vec_valid4, dout4);
        end
        rst = 1'b0;
        tick();
        inta = 1'b1;
        tick();
        inta = 1'b0;
        vectors++; if (vec_valid4 !== 1'b0) begin errors++; $display("FAIL n4_no_vec: got %b want 0", vec_valid4); end
        tick();
        vectors++; if (vec_valid4 !== 1'b0) begin errors++; $display("FAIL n4_no_vec2: got %b want 0", vec_valid4); end
        do_write(1'b0, 8'h08);
        do_read(1'b0, r8, r4);
        vectors++; if (r4 !== 8'h00) begin errors++; $display("FAIL n4_isr: got %h want 00", r4); end
    endtask

    initial begin
        test_reset();
        test_nested();
        test_rotate();
        test_aeoi();
        test_spurious();
        test_four_rst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
